// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, phase-aligned to the start edge; outputs update
// the cycle after the stop-bit sample. No backpressure: rx_done is a level flag, cleared by the next start edge.
module uart_rx #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_busy,
    output logic       frame_err
);

    localparam int DIV   = CLK_HZ / (BAUD * 16);
    localparam int DIV_C = (DIV < 1) ? 1 : DIV;
    localparam int TW    = (DIV_C > 1) ? $clog2(DIV_C) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(DIV_C - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, rxs_q, rxs_prev_q;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [3:0]      sub_q, sub_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;
    logic            tick;

    assign tick = (state_q != IDLE) && (tcnt_q == TICK_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            state_q    <= IDLE;
            tcnt_q     <= '0;
            sub_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            sync1_q    <= rxd;
            rxs_q      <= sync1_q;
            rxs_prev_q <= rxs_q;
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            sub_q      <= sub_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tcnt_d  = tick ? '0 : tcnt_q + TW'(1);
        sub_d   = sub_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = done_q;
        ferr_d  = ferr_q;
        case (state_q)
            IDLE: begin
                // Counter parked at 0 so the first tick lands DIV cycles after the edge.
                tcnt_d = '0;
                if (rxs_prev_q && !rxs_q) begin
                    state_d = START;
                    sub_d   = '0;
                    idx_d   = '0;
                    done_d  = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    if (sub_q == 4'd7) begin
                        sub_d   = '0;
                        state_d = rxs_q ? IDLE : DATA;
                    end else begin
                        sub_d = sub_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    sub_d = sub_q + 4'd1;
                    if (sub_q == 4'd15) begin
                        shift_d[idx_q] = rxs_q;
                        idx_d          = idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_d = STOP;
                        end
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    sub_d = sub_q + 4'd1;
                    if (sub_q == 4'd15) begin
                        if (rxs_q) begin
                            data_d  = shift_q;
                            done_d  = 1'b1;
                            ferr_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = WAIT_HIGH;
                        end
                    end
                end
            end
            WAIT_HIGH: begin
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data   = data_q;
    assign rx_done   = done_q;
    assign rx_busy   = (state_q != IDLE);
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at CLK_HZ=640, BAUD=10 (64 clk per bit). Expected frame outcomes are queued
// by the stimulus and checked by a monitor on each rising rx_done / frame_err.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_busy;
    logic       frame_err;

    uart_rx #(.CLK_HZ(640), .BAUD(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .rx_busy   (rx_busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        bit         is_ferr;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    logic prev_done = 1'b0;
    logic prev_ferr = 1'b0;

    task automatic check(input string name, input int act, input int exp_v);
        n_total++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input bit is_ferr, input logic [7:0] d);
        exp_t e;
        e.is_ferr = is_ferr;
        e.data    = d;
        exp_q.push_back(e);
    endtask

    task automatic send_tail(input logic [7:0] d, input logic stopb, input int bl);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            clks(bl);
        end
        rxd = stopb;
        clks(bl);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stopb, input int bl);
        rxd = 1'b0;
        clks(bl);
        send_tail(d, stopb, bl);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rx_done && !prev_done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done_event", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_event_kind", 0, int'(mon_e.is_ferr));
                check("done_rx_data", int'(rx_data), int'(mon_e.data));
                check("done_frame_err", int'(frame_err), 0);
            end
        end
        if (frame_err && !prev_ferr) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ferr_event", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("ferr_event_kind", 1, int'(mon_e.is_ferr));
                check("ferr_rx_data", int'(rx_data), int'(mon_e.data));
                check("ferr_rx_done", int'(rx_done), 0);
            end
        end
        prev_done = rx_done;
        prev_ferr = frame_err;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clks(3);
        check("reset_rx_data", int'(rx_data), 0);
        check("reset_rx_done", int'(rx_done), 0);
        check("reset_rx_busy", int'(rx_busy), 0);
        check("reset_frame_err", int'(frame_err), 0);
        rst = 1'b0;
        clks(5);

        // Single good frame, then a long idle
        expect_ev(1'b0, 8'hA5);
        send_byte(8'hA5, 1'b1, 64);
        check("a5_busy_after", int'(rx_busy), 0);
        clks(200);
        check("a5_done_held", int'(rx_done), 1);
        check("a5_data_held", int'(rx_data), 8'hA5);
        check("a5_ferr", int'(frame_err), 0);

        // Back-to-back frames
        expect_ev(1'b0, 8'h3C);
        expect_ev(1'b0, 8'hC3);
        send_byte(8'h3C, 1'b1, 64);
        rxd = 1'b0;
        clks(6);
        check("b2b_done_dropped", int'(rx_done), 0);
        check("b2b_data_kept", int'(rx_data), 8'h3C);
        check("b2b_busy", int'(rx_busy), 1);
        clks(58);
        send_tail(8'hC3, 1'b1, 64);
        clks(5);
        check("c3_data", int'(rx_data), 8'hC3);
        check("c3_done", int'(rx_done), 1);

        // Bad stop bit followed by a long low line
        expect_ev(1'b1, 8'hC3);
        send_byte(8'h55, 1'b0, 64);
        clks(300);
        check("ferr_set", int'(frame_err), 1);
        check("ferr_data_kept", int'(rx_data), 8'hC3);
        check("ferr_done_low", int'(rx_done), 0);
        check("ferr_wait_high_busy", int'(rx_busy), 1);
        rxd = 1'b1;
        clks(10);
        check("ferr_idle_after_high", int'(rx_busy), 0);
        check("ferr_held", int'(frame_err), 1);

        // 20-clk glitch: false start
        rxd = 1'b0;
        clks(6);
        check("glitch_busy", int'(rx_busy), 1);
        clks(14);
        rxd = 1'b1;
        clks(60);
        check("glitch_idle", int'(rx_busy), 0);
        check("glitch_done", int'(rx_done), 0);
        check("glitch_data", int'(rx_data), 8'hC3);

        expect_ev(1'b0, 8'h81);
        send_byte(8'h81, 1'b1, 64);
        clks(5);
        check("x81_data", int'(rx_data), 8'h81);
        check("x81_ferr_cleared", int'(frame_err), 0);

        // Reset during bit 4 of 0xFF
        rxd = 1'b0;
        clks(64);
        rxd = 1'b1;
        clks(4 * 64 + 32);
        rst = 1'b1;
        #1;
        check("rst_mid_rx_data", int'(rx_data), 0);
        check("rst_mid_rx_done", int'(rx_done), 0);
        check("rst_mid_rx_busy", int'(rx_busy), 0);
        check("rst_mid_frame_err", int'(frame_err), 0);
        clks(3);
        rst = 1'b0;
        clks(300);
        check("rst_after_done", int'(rx_done), 0);
        check("rst_after_busy", int'(rx_busy), 0);
        check("rst_after_data", int'(rx_data), 0);

        expect_ev(1'b0, 8'h12);
        send_byte(8'h12, 1'b1, 64);
        clks(5);
        check("x12_data", int'(rx_data), 8'h12);
        check("x12_done", int'(rx_done), 1);

        // Transmitter ~3% slower than the receiver's bit clock
        expect_ev(1'b0, 8'h00);
        send_byte(8'h00, 1'b1, 66);
        clks(20);
        check("slow_tx_data", int'(rx_data), 0);
        check("slow_tx_ferr", int'(frame_err), 0);
        check("slow_tx_done", int'(rx_done), 1);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate.
REQ-003 SHALL have input clk, 1 bit: system clock, all logic on its rising edge.
REQ-004 SHALL have input rst, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have input rxd, 1 bit: asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have output rx_data, 8 bits: last correctly framed byte; feeds the CPU I/O block's UART receive-data register.
REQ-007 SHALL have output rx_done, 1 bit: byte-available flag; feeds the I/O block's UART status bit 0.
REQ-008 SHALL have output rx_busy, 1 bit: high while a frame is in progress (any state except IDLE).
REQ-009 SHALL have output frame_err, 1 bit: last frame had a stop bit of 0.

Function
REQ-010 SHALL pass rxd through a 2-flop synchronizer, both flops reset to 1; all logic uses only the synchronized value (rxs).
REQ-011 SHALL generate a 16x oversample tick: DIV = CLK_HZ/(BAUD*16), integer truncation; tick counter counts 0..DIV-1 and asserts tick for one cycle on wrap.
REQ-012 SHALL hold the tick counter at 0 in IDLE and restart it at 0 on the cycle a start edge is detected, so that sampling is phase-aligned to the edge.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE: on rxs sampled 1 in the previous cycle and 0 in this cycle (falling edge) SHALL go to START, clear the tick-count-in-bit (sub) counter and the bit index, and clear rx_done.
REQ-015 START: after 8 ticks (mid start bit) SHALL sample rxs; 0 -> DATA with sub=0; 1 -> false start, back to IDLE with rx_done remaining 0.
REQ-016 DATA: every 16 ticks SHALL sample rxs into shift register bit position [index], index 0..7; after index 7 -> STOP.
REQ-017 STOP: after 16 ticks SHALL sample rxs; 1 -> load rx_data from shift register, set rx_done=1, clear frame_err, go to IDLE; 0 -> set frame_err=1, leave rx_data and rx_done unchanged, go to WAIT_HIGH.
REQ-018 WAIT_HIGH: SHALL remain until rxs=1 (break/line-low condition), then go to IDLE; no edge detection while in this state.
REQ-019 rx_data, rx_done, frame_err SHALL update on the clock edge following the stop-bit sample tick; the shift register SHALL never be visible on rx_data mid-frame.
REQ-020 rx_done SHALL be level, held high from frame acceptance until the next start edge detection (REQ-014) or reset; a following false start therefore clears it.
REQ-021 frame_err SHALL be held until the next successful stop-bit sample or reset.
REQ-022 A start edge arriving in the same cycle the STOP->IDLE transition occurs SHALL be ignored; detection begins the cycle after IDLE is entered.
REQ-023 Bit index and sub counters SHALL be 3 and 4 bits respectively and wrap naturally; no other arithmetic exceeds these widths.

Reset
REQ-024 On rst high, asynchronously: state=IDLE, synchronizer flops=1, counters=0, shift register=0, rx_data=0x00, rx_done=0, rx_busy=0, frame_err=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no rx_data update; after release, the block SHALL wait for a fresh falling edge.

Verification (CLK_HZ=640, BAUD=10: DIV=4, 64 clk/bit)
REQ-026 Send 0xA5 with stop=1 -> rx_data=0xA5, rx_done=1, frame_err=0, rx_busy low after the frame; rx_done stays 1 for 200 idle cycles.
REQ-027 Send 0x3C then 0xC3 back-to-back (no idle gap) -> rx_data=0x3C, then rx_done drops at the second start edge, then rx_data=0xC3, rx_done=1.
REQ-028 Low glitch of 20 clk on idle line -> false start, state returns IDLE, rx_done and rx_data unchanged from prior values.
REQ-029 Send 0x55 with stop=0, hold line low 300 clk, then high -> frame_err=1, rx_data keeps previous value, no new frame until line high; next good 0x81 -> rx_data=0x81, frame_err=0.
REQ-030 Assert rst during bit 4 of 0xFF -> all outputs 0 immediately; after release, good 0x12 -> rx_data=0x12, rx_done=1.
REQ-031 Send 0x00 with receiver clock 3% fast vs transmitter -> rx_data=0x00, frame_err=0.
